cache_ctrl_param: RTL and testbench
===================================

CACHE_CTRL_PARAM -- requirements
Module: cache_ctrl_param

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 32, byte-address width.
- WORD_W, 32, CPU word width; a multiple of 8.
- LINE_WORDS, 4, words per line; a power of 2, at least 2; LINE_W = WORD_W*LINE_WORDS.
- NUM_LINES, 1024, direct-mapped lines; a power of 2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, single clock; all logic on its rising edge.
- RESETn, in, 1, reset; synchronous, active-low.
- cpu_req_valid, in, 1, CPU request present.
- cpu_req_rw, in, 1, 1=write, 0=read.
- cpu_req_addr, in, ADDR_W, byte address.
- cpu_req_datain, in, WORD_W, write data.
- cpu_res_dataout, out, WORD_W, read data, or echoed write data.
- cpu_res_valid, out, 1, one-cycle response strobe.
- cache_ready, out, 1, controller can accept a request.
- mem_req_valid, out, 1, memory request.
- mem_req_rw, out, 1, 1=write-back, 0=line fill.
- mem_req_addr, out, ADDR_W, line-aligned address.
- mem_req_dataout, out, LINE_W, write-back line.
- mem_req_datain, in, LINE_W, fill line.
- mem_req_ready, in, 1, memory completes the request on this edge.
- cnt_clr, in, 1, synchronous clear of both counters.
- hit_cnt, out, 32, saturating hit count.
- miss_cnt, out, 32, saturating miss count.

Function
REQ-003 Address fields SHALL be split, from LSB up, as:
- byte offset: log2(WORD_W/8) bits, ignored;
- word select: log2(LINE_WORDS) bits;
- index: log2(NUM_LINES) bits;
- tag: the remaining bits.
REQ-004 The FSM SHALL have states IDLE, COMPARE, WRITE_BACK and ALLOCATE.
REQ-005 cache_ready SHALL equal (state==IDLE).
REQ-006 A request SHALL be accepted on an edge where cpu_req_valid and cache_ready are both 1; the controller latches addr, rw and datain and moves to COMPARE.
REQ-007 In COMPARE, a hit (valid and tag equal) SHALL return to IDLE.
- read hit: cpu_res_dataout = selected word;
- write hit: the word is updated, dirty=1, and cpu_res_dataout = the written word;
- in both cases cpu_res_valid is high for exactly one cycle, beginning 2 edges after acceptance.
REQ-008 In COMPARE, a miss SHALL go to WRITE_BACK if the line is valid and dirty, else to ALLOCATE.
REQ-009 In WRITE_BACK the controller SHALL drive:
- mem_req_valid=1, mem_req_rw=1;
- mem_req_addr = {old tag, index, zeros};
- mem_req_dataout = the stored line.
On an edge with mem_req_ready=1 it SHALL move to ALLOCATE.
REQ-010 In ALLOCATE the controller SHALL drive mem_req_valid=1, mem_req_rw=0 and mem_req_addr = {new tag, index, zeros}. On an edge with mem_req_ready=1 it SHALL:
- write mem_req_datain into the line;
- set valid=1, dirty=0, tag=new tag;
- return to COMPARE, where the retry hits.
REQ-011 All mem_req_* outputs SHALL stay stable while mem_req_valid=1 and mem_req_ready=0.
REQ-012 mem_req_valid SHALL drop on the edge on which mem_req_ready is sampled high.
REQ-013 mem_req_ready while mem_req_valid=0 SHALL be ignored.
REQ-014 hit_cnt or miss_cnt SHALL increment once per request, on its first COMPARE only; the retry COMPARE after ALLOCATE is not counted.
REQ-015 Counters SHALL saturate at 32'hFFFF_FFFF.
REQ-016 cnt_clr SHALL take priority over a same-cycle increment.
REQ-017 cpu_req_valid while cache_ready=0 SHALL be ignored; no queuing.

Reset
REQ-018 On an edge with RESETn=0 the controller SHALL:
- go to IDLE;
- clear all valid and dirty bits;
- set cpu_res_valid, cpu_res_dataout, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_dataout, hit_cnt and miss_cnt to 0;
- set cache_ready to 1.
REQ-019 Tag and data arrays SHALL NOT be reset.
REQ-020 Reset during WRITE_BACK or ALLOCATE SHALL abandon the memory transaction (mem_req_valid=0 after the edge) and discard dirty data.

Structure
REQ-021 Package cache_pkg SHALL hold:
- the cache_state_e enum;
- parameter defaults;
- functions deriving field widths from the parameters.
REQ-022 Tag, valid, dirty and data storage SHALL be the sub-module cache_line_store (one read port, one write port).
REQ-023 The FSM, latches and counters SHALL sit in cache_ctrl_param.

Verification (default parameters; index = addr[13:4])
REQ-024 After reset, read 0x0000_1000:
- expect ALLOCATE with mem_req_addr=0x0000_1000, rw=0;
- ready after 3 cycles with datain word0=0xAAAA_AAAA;
- expect cpu_res_dataout=0xAAAA_AAAA, miss_cnt=1, hit_cnt=0.
REQ-025 Write 0x0000_1004 with 0xDEAD_BEEF, then read 0x0000_1004:
- both requests get a one-cycle cpu_res_valid, each 2 edges after acceptance;
- the read returns 0xDEAD_BEEF;
- hit_cnt=2.
REQ-026 Then read 0x0000_5004 (same index, new tag):
- expect WRITE_BACK with addr 0x0000_1000, rw=1, dataout word1=0xDEAD_BEEF;
- then ALLOCATE with addr 0x0000_5000;
- miss_cnt=2.
REQ-027 Hold mem_req_ready=0 for 10 cycles during ALLOCATE: all mem_req_* outputs stay stable and cache_ready=0 throughout.
REQ-028 Drive RESETn=0 for one edge during ALLOCATE: mem_req_valid=0 and cache_ready=1 next cycle; a later read of 0x0000_1000 misses.
REQ-029 Assert cnt_clr in the COMPARE cycle of a hit: hit_cnt=0 after that edge.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_pkg
// Brief   : Shared state encoding, parameter defaults and address-field
//           width helpers for the direct-mapped cache controller.
// Rev     : 1.0  initial release
// ============================================================================
package cache_pkg;

    localparam int unsigned c_DEF_ADDR_W     = 32;
    localparam int unsigned c_DEF_WORD_W     = 32;
    localparam int unsigned c_DEF_LINE_WORDS = 4;
    localparam int unsigned c_DEF_NUM_LINES  = 1024;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } cache_state_e;

    function automatic int unsigned off_bits(input int unsigned word_w);
        return $clog2(word_w / 8);
    endfunction

    function automatic int unsigned sel_bits(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_w,
                                             input int unsigned word_w,
                                             input int unsigned line_words,
                                             input int unsigned num_lines);
        return addr_w - off_bits(word_w) - sel_bits(line_words) - idx_bits(num_lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
// Module  : cache_line_store
// Brief   : Tag/data/valid/dirty storage, one async read port, one write port.
// Rev     : 1.0  initial release
// ============================================================================
module cache_line_store
    import cache_pkg::*;
#(
    parameter int TAG_W     = 18,
    parameter int IDX_W     = 10,
    parameter int LINE_W    = 128,
    parameter int NUM_LINES = 1024
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              wr_dirty
);

    logic [TAG_W-1:0]     r_tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    r_data_mem [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    // Arrays carry no reset; only the status bits are cleared.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            r_tag_mem[wr_idx]  <= wr_tag;
            r_data_mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
            r_dirty[wr_idx] <= wr_dirty;
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_dirty = r_dirty[rd_idx];
    assign rd_tag   = r_tag_mem[rd_idx];
    assign rd_data  = r_data_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module  : cache_ctrl_param
// Brief   : Direct-mapped write-back cache controller with hit/miss counters.
// Rev     : 1.0  initial release
// ============================================================================
module cache_ctrl_param
    import cache_pkg::*;
#(
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int WORD_W     = c_DEF_WORD_W,
    parameter int LINE_WORDS = c_DEF_LINE_WORDS,
    parameter int NUM_LINES  = c_DEF_NUM_LINES
) (
    input  logic                         CLK,
    input  logic                         RESETn,
    input  logic                         cpu_req_valid,
    input  logic                         cpu_req_rw,
    input  logic [ADDR_W-1:0]            cpu_req_addr,
    input  logic [WORD_W-1:0]            cpu_req_datain,
    output logic [WORD_W-1:0]            cpu_res_dataout,
    output logic                         cpu_res_valid,
    output logic                         cache_ready,
    output logic                         mem_req_valid,
    output logic                         mem_req_rw,
    output logic [ADDR_W-1:0]            mem_req_addr,
    output logic [WORD_W*LINE_WORDS-1:0] mem_req_dataout,
    input  logic [WORD_W*LINE_WORDS-1:0] mem_req_datain,
    input  logic                         mem_req_ready,
    input  logic                         cnt_clr,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt
);

    localparam int c_OFF_W  = off_bits(WORD_W);
    localparam int c_SEL_W  = sel_bits(LINE_WORDS);
    localparam int c_IDX_W  = idx_bits(NUM_LINES);
    localparam int c_TAG_W  = tag_bits(ADDR_W, WORD_W, LINE_WORDS, NUM_LINES);
    localparam int c_LINE_W = WORD_W * LINE_WORDS;

    cache_state_e        r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rw;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_first;
    logic                r_rsp_pend;
    logic [WORD_W-1:0]   r_rsp_data;

    logic [c_IDX_W-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic [c_SEL_W-1:0]  w_sel;
    logic                w_line_valid;
    logic                w_line_dirty;
    logic [c_TAG_W-1:0]  w_line_tag;
    logic [c_LINE_W-1:0] w_line_data;
    logic                w_hit;
    logic [WORD_W-1:0]   w_word;
    logic                w_wr_en;
    logic                w_wr_dirty;
    logic [c_LINE_W-1:0] w_wr_data;
    logic                w_unused;

    assign w_idx    = r_addr[c_OFF_W+c_SEL_W +: c_IDX_W];
    assign w_tag    = r_addr[ADDR_W-1 -: c_TAG_W];
    assign w_sel    = r_addr[c_OFF_W +: c_SEL_W];
    assign w_unused = ^r_addr[c_OFF_W-1:0];

    assign w_hit       = w_line_valid && (w_line_tag == w_tag);
    assign w_word      = w_line_data[int'(w_sel)*WORD_W +: WORD_W];
    assign cache_ready = (r_state == IDLE);

    // Write hits merge one word into the stored line; fills replace it whole.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_dirty = 1'b0;
        w_wr_data  = w_line_data;
        if (r_state == COMPARE && w_hit && r_rw) begin
            w_wr_en    = 1'b1;
            w_wr_dirty = 1'b1;
            w_wr_data[int'(w_sel)*WORD_W +: WORD_W] = r_wdata;
        end else if (r_state == ALLOCATE && mem_req_ready) begin
            w_wr_en   = 1'b1;
            w_wr_data = mem_req_datain;
        end
    end

    cache_line_store #(
        .TAG_W     (c_TAG_W),
        .IDX_W     (c_IDX_W),
        .LINE_W    (c_LINE_W),
        .NUM_LINES (NUM_LINES)
    ) u_store (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .rd_idx   (w_idx),
        .rd_valid (w_line_valid),
        .rd_dirty (w_line_dirty),
        .rd_tag   (w_line_tag),
        .rd_data  (w_line_data),
        .wr_en    (w_wr_en),
        .wr_idx   (w_idx),
        .wr_tag   (w_tag),
        .wr_data  (w_wr_data),
        .wr_dirty (w_wr_dirty)
    );

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_rw            <= 1'b0;
            r_wdata         <= '0;
            r_first         <= 1'b0;
            r_rsp_pend      <= 1'b0;
            r_rsp_data      <= '0;
            cpu_res_valid   <= 1'b0;
            cpu_res_dataout <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_rw      <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_dataout <= '0;
        end else begin
            // Hit result is staged one cycle so the strobe lands two edges after acceptance.
            r_rsp_pend    <= 1'b0;
            cpu_res_valid <= r_rsp_pend;
            if (r_rsp_pend) begin
                cpu_res_dataout <= r_rsp_data;
            end
            case (r_state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        r_addr  <= cpu_req_addr;
                        r_rw    <= cpu_req_rw;
                        r_wdata <= cpu_req_datain;
                        r_first <= 1'b1;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    r_first <= 1'b0;
                    if (w_hit) begin
                        r_rsp_pend <= 1'b1;
                        r_rsp_data <= r_rw ? r_wdata : w_word;
                        r_state    <= IDLE;
                    end else if (w_line_valid && w_line_dirty) begin
                        mem_req_valid   <= 1'b1;
                        mem_req_rw      <= 1'b1;
                        mem_req_addr    <= {w_line_tag, w_idx, {(c_OFF_W+c_SEL_W){1'b0}}};
                        mem_req_dataout <= w_line_data;
                        r_state         <= WRITE_BACK;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_rw    <= 1'b0;
                        mem_req_addr  <= {w_tag, w_idx, {(c_OFF_W+c_SEL_W){1'b0}}};
                        r_state       <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (mem_req_ready) begin
                        mem_req_rw   <= 1'b0;
                        mem_req_addr <= {w_tag, w_idx, {(c_OFF_W+c_SEL_W){1'b0}}};
                        r_state      <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= COMPARE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn || cnt_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == COMPARE && r_first) begin
            if (w_hit && hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (!w_hit && miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_ctrl_param
// Brief   : Directed self-checking bench for cache_ctrl_param (default params).
// Rev     : 1.0  initial release
// ============================================================================
module tb_cache_ctrl_param;

    logic         CLK = 1'b0;
    logic         RESETn;
    logic         cpu_req_valid;
    logic         cpu_req_rw;
    logic [31:0]  cpu_req_addr;
    logic [31:0]  cpu_req_datain;
    logic [31:0]  cpu_res_dataout;
    logic         cpu_res_valid;
    logic         cache_ready;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_dataout;
    logic [127:0] mem_req_datain;
    logic         mem_req_ready;
    logic         cnt_clr;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] c_FILL_A = 128'h4444_4444_3333_3333_2222_2222_AAAA_AAAA;
    localparam logic [127:0] c_WB_A   = 128'h4444_4444_3333_3333_DEAD_BEEF_AAAA_AAAA;
    localparam logic [127:0] c_FILL_B = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

    cache_ctrl_param dut (
        .CLK             (CLK),
        .RESETn          (RESETn),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_rw      (cpu_req_rw),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_datain  (cpu_req_datain),
        .cpu_res_dataout (cpu_res_dataout),
        .cpu_res_valid   (cpu_res_valid),
        .cache_ready     (cache_ready),
        .mem_req_valid   (mem_req_valid),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_dataout (mem_req_dataout),
        .mem_req_datain  (mem_req_datain),
        .mem_req_ready   (mem_req_ready),
        .cnt_clr         (cnt_clr),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data);
        cpu_req_valid  = 1'b1;
        cpu_req_rw     = rw;
        cpu_req_addr   = addr;
        cpu_req_datain = data;
        tick();
        cpu_req_valid  = 1'b0;
    endtask

    initial begin
        RESETn         = 1'b0;
        cpu_req_valid  = 1'b0;
        cpu_req_rw     = 1'b0;
        cpu_req_addr   = '0;
        cpu_req_datain = '0;
        mem_req_datain = '0;
        mem_req_ready  = 1'b0;
        cnt_clr        = 1'b0;
        tick();
        tick();
        RESETn = 1'b1;
        check("rst_ready", 128'(cache_ready), 128'(1));
        check("rst_mvalid", 128'(mem_req_valid), 128'(0));
        check("rst_rvalid", 128'(cpu_res_valid), 128'(0));
        check("rst_hit", 128'(hit_cnt), 128'(0));
        check("rst_miss", 128'(miss_cnt), 128'(0));

        // Cold read miss of 0x1000, fill ready on the third ALLOCATE cycle
        issue(1'b0, 32'h0000_1000, 32'h0);
        check("cmp_busy", 128'(cache_ready), 128'(0));
        tick();
        check("alloc_valid", 128'(mem_req_valid), 128'(1));
        check("alloc_rw", 128'(mem_req_rw), 128'(0));
        check("alloc_addr", 128'(mem_req_addr), 128'(32'h0000_1000));
        check("miss1", 128'(miss_cnt), 128'(1));
        tick();
        tick();
        mem_req_datain = c_FILL_A;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        check("fill_drop", 128'(mem_req_valid), 128'(0));
        tick();
        check("retry_norsp", 128'(cpu_res_valid), 128'(0));
        tick();
        check("rd1_valid", 128'(cpu_res_valid), 128'(1));
        check("rd1_data", 128'(cpu_res_dataout), 128'(32'hAAAA_AAAA));
        check("rd1_miss", 128'(miss_cnt), 128'(1));
        check("rd1_hit", 128'(hit_cnt), 128'(0));
        tick();
        check("rd1_pulse", 128'(cpu_res_valid), 128'(0));

        // Write hit then read hit on 0x1004
        issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        check("wr_e0", 128'(cpu_res_valid), 128'(0));
        tick();
        check("wr_e1", 128'(cpu_res_valid), 128'(0));
        tick();
        check("wr_e2", 128'(cpu_res_valid), 128'(1));
        check("wr_echo", 128'(cpu_res_dataout), 128'(32'hDEAD_BEEF));
        tick();
        check("wr_pulse", 128'(cpu_res_valid), 128'(0));
        issue(1'b0, 32'h0000_1004, 32'h0);
        tick();
        check("rd2_e1", 128'(cpu_res_valid), 128'(0));
        tick();
        check("rd2_valid", 128'(cpu_res_valid), 128'(1));
        check("rd2_data", 128'(cpu_res_dataout), 128'(32'hDEAD_BEEF));
        check("rd2_hit", 128'(hit_cnt), 128'(2));
        tick();
        check("rd2_pulse", 128'(cpu_res_valid), 128'(0));

        // Conflict miss on dirty line: write-back then allocate
        issue(1'b0, 32'h0000_5004, 32'h0);
        tick();
        check("wb_valid", 128'(mem_req_valid), 128'(1));
        check("wb_rw", 128'(mem_req_rw), 128'(1));
        check("wb_addr", 128'(mem_req_addr), 128'(32'h0000_1000));
        check("wb_data", mem_req_dataout, c_WB_A);
        check("miss2", 128'(miss_cnt), 128'(2));
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("al2_valid", 128'(mem_req_valid), 128'(1));
        check("al2_rw", 128'(mem_req_rw), 128'(0));
        check("al2_addr", 128'(mem_req_addr), 128'(32'h0000_5000));

        // Stall ALLOCATE ten cycles with a CPU request knocking meanwhile
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h0000_9000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 128'(mem_req_valid), 128'(1));
            check("hold_rw", 128'(mem_req_rw), 128'(0));
            check("hold_addr", 128'(mem_req_addr), 128'(32'h0000_5000));
            check("hold_data", mem_req_dataout, c_WB_A);
            check("hold_ready", 128'(cache_ready), 128'(0));
        end
        cpu_req_valid = 1'b0;

        // Reset mid-ALLOCATE abandons the fill and invalidates the cache
        RESETn = 1'b0;
        tick();
        RESETn = 1'b1;
        check("ar_mvalid", 128'(mem_req_valid), 128'(0));
        check("ar_ready", 128'(cache_ready), 128'(1));
        check("ar_miss", 128'(miss_cnt), 128'(0));

        // Stray mem_req_ready while idle has no effect
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("stray_ready", 128'(cache_ready), 128'(1));
        check("stray_mvalid", 128'(mem_req_valid), 128'(0));

        issue(1'b0, 32'h0000_1000, 32'h0);
        tick();
        check("rm_valid", 128'(mem_req_valid), 128'(1));
        check("rm_rw", 128'(mem_req_rw), 128'(0));
        check("rm_addr", 128'(mem_req_addr), 128'(32'h0000_1000));
        check("rm_miss", 128'(miss_cnt), 128'(1));
        mem_req_datain = c_FILL_B;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        tick();
        tick();
        check("rm_rvalid", 128'(cpu_res_valid), 128'(1));
        check("rm_data", 128'(cpu_res_dataout), 128'(32'h5555_5555));
        check("rm_hit", 128'(hit_cnt), 128'(0));

        // Counter clear coinciding with a hit's COMPARE cycle
        issue(1'b0, 32'h0000_1008, 32'h0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_hit", 128'(hit_cnt), 128'(0));
        check("clr_miss", 128'(miss_cnt), 128'(0));
        tick();
        check("clr_rvalid", 128'(cpu_res_valid), 128'(1));
        check("clr_data", 128'(cpu_res_dataout), 128'(32'h7777_7777));
        issue(1'b0, 32'h0000_100C, 32'h0);
        tick();
        check("post_hit", 128'(hit_cnt), 128'(1));
        tick();
        check("post_data", 128'(cpu_res_dataout), 128'(32'h8888_8888));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
